immediate_generator: RTL and testbench

IMMEDIATE_GENERATOR -- requirements
Module: immediate_generator

---
 rtl/immgen_pkg.sv | 21 ++
 rtl/immediate_decode.sv | 37 +++
 rtl/immediate_generator.sv | 60 ++++++
 tb/tb_immediate_generator.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/immgen_pkg.sv
// Shared immediate-format encodings for the immediate generator and its decoder.
// Contents:
//   IMM_* : 3-bit immediate format select codes (3'd6 and 3'd7 are reserved)
//   imm_res_t : decoded immediate plus reserved-code flag
package immgen_pkg;

  localparam int unsigned ImmSelW = 3;

  localparam logic [ImmSelW-1:0] IMM_ITYPE = 3'd0;
  localparam logic [ImmSelW-1:0] IMM_STYPE = 3'd1;
  localparam logic [ImmSelW-1:0] IMM_BTYPE = 3'd2;
  localparam logic [ImmSelW-1:0] IMM_UTYPE = 3'd3;
  localparam logic [ImmSelW-1:0] IMM_JTYPE = 3'd4;
  localparam logic [ImmSelW-1:0] IMM_ZTYPE = 3'd5;  // CSR uimm

  typedef struct packed {
    logic [31:0] imm;
    logic        illegal;
  } imm_res_t;

endpackage

// File: rtl/immediate_decode.sv
// Combinational immediate extraction from an RV32 instruction word.
// Ports:
//   sel_i  : immediate format select (IMM_* codes)
//   data_i : raw instruction word
//   res_o  : extended immediate and reserved-code flag (imm forced to 0 when illegal)
module immediate_decode
  import immgen_pkg::*;
(
  input  logic [ImmSelW-1:0] sel_i,
  input  logic [31:0]        data_i,
  output imm_res_t           res_o
);

  logic sign;
  assign sign = data_i[31];

  // Opcode bits never contribute to any immediate.
  logic unused_opcode;
  assign unused_opcode = ^data_i[6:0];

  always_comb begin
    res_o.imm     = 32'h0;
    res_o.illegal = 1'b0;
    case (sel_i)
      IMM_ITYPE: res_o.imm = {{20{sign}}, data_i[31:20]};
      IMM_STYPE: res_o.imm = {{20{sign}}, data_i[31:25], data_i[11:7]};
      IMM_BTYPE: res_o.imm = {{19{sign}}, data_i[31], data_i[7], data_i[30:25],
                              data_i[11:8], 1'b0};
      IMM_UTYPE: res_o.imm = {data_i[31:12], 12'b0};
      IMM_JTYPE: res_o.imm = {{11{sign}}, data_i[31], data_i[19:12], data_i[20],
                              data_i[30:21], 1'b0};
      IMM_ZTYPE: res_o.imm = {27'b0, data_i[19:15]};
      default:   res_o.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/immediate_generator.sv
// Registered RV32 immediate generator: one-cycle latency, full throughput.
// Ports:
//   I_clk, I_rst : clock, asynchronous active-high reset
//   I_valid      : qualifies I_immsel / I_data
//   I_immsel     : immediate format select (IMM_* codes)
//   I_data       : raw instruction word
//   O_data       : registered immediate (holds while I_valid is low)
//   O_valid      : I_valid delayed by one cycle
//   O_illegal    : the result in O_data came from a reserved select code
module immediate_generator
  import immgen_pkg::*;
(
  input  logic               I_clk,
  input  logic               I_rst,
  input  logic               I_valid,
  input  logic [ImmSelW-1:0] I_immsel,
  input  logic [31:0]        I_data,
  output logic [31:0]        O_data,
  output logic               O_valid,
  output logic               O_illegal
);

  imm_res_t    dec_res;
  logic [31:0] data_d, data_q;
  logic        illegal_d, illegal_q;
  logic        valid_q;

  immediate_decode u_decode (
    .sel_i  (I_immsel),
    .data_i (I_data),
    .res_o  (dec_res)
  );

  // Result registers only load on a valid input so the last result is held.
  always_comb begin
    data_d    = data_q;
    illegal_d = illegal_q;
    if (I_valid) begin
      data_d    = dec_res.imm;
      illegal_d = dec_res.illegal;
    end
  end

  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      data_q    <= 32'h0;
      illegal_q <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      data_q    <= data_d;
      illegal_q <= illegal_d;
      valid_q   <= I_valid;
    end
  end

  assign O_data    = data_q;
  assign O_illegal = illegal_q;
  assign O_valid   = valid_q;

endmodule

// File: tb/tb_immediate_generator.sv
module tb_immediate_generator;
  import immgen_pkg::*;

  logic        I_clk = 1'b0;
  logic        I_rst;
  logic        I_valid;
  logic [2:0]  I_immsel;
  logic [31:0] I_data;
  logic [31:0] O_data;
  logic        O_valid;
  logic        O_illegal;

  immediate_generator dut (
    .I_clk     (I_clk),
    .I_rst     (I_rst),
    .I_valid   (I_valid),
    .I_immsel  (I_immsel),
    .I_data    (I_data),
    .O_data    (O_data),
    .O_valid   (O_valid),
    .O_illegal (O_illegal)
  );

  always #5 I_clk = ~I_clk;

  typedef struct {
    logic [31:0] data;
    logic        illegal;
  } exp_t;

  typedef struct {
    string       name;
    logic [2:0]  sel;
    logic [31:0] d;
    logic [31:0] exp;
    logic        ill;
  } vec_t;

  exp_t scb[$];
  int   checks = 0;
  int   errors = 0;
  logic exp_valid;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference model written with arithmetic shifts rather than concatenations.
  function automatic logic [31:0] model(input logic [2:0] sel, input logic [31:0] d);
    logic signed [31:0] s;
    logic [31:0] hi;
    s = d;
    case (sel)
      3'd0: return 32'(s >>> 20);
      3'd1: begin
        hi = 32'(s >>> 25);
        return (hi << 5) | ((d >> 7) & 32'h1f);
      end
      3'd2: begin
        hi = 32'(s >>> 31);
        return (hi << 12) | (((d >> 7) & 32'h1) << 11) | (((d >> 25) & 32'h3f) << 5)
             | (((d >> 8) & 32'hf) << 1);
      end
      3'd3: return d & 32'hffff_f000;
      3'd4: begin
        hi = 32'(s >>> 31);
        return (hi << 20) | (d & 32'h000f_f000) | (((d >> 20) & 32'h1) << 11)
             | (((d >> 21) & 32'h3ff) << 1);
      end
      3'd5: return (d >> 15) & 32'h1f;
      default: return 32'h0;
    endcase
  endfunction

  // Expected O_valid: I_valid delayed one cycle, cleared by reset.
  always @(posedge I_clk or posedge I_rst) begin
    if (I_rst) exp_valid <= 1'b0;
    else       exp_valid <= I_valid;
  end

  // Scoreboard checker, sampled on the falling edge.
  always @(negedge I_clk) begin
    exp_t e;
    if (I_rst) begin
      scb.delete();
    end else begin
      check("o_valid_timing", {31'b0, O_valid}, {31'b0, exp_valid});
      if (O_valid) begin
        if (scb.size() == 0) begin
          check("scb_underflow", 32'd0, 32'd1);
        end else begin
          e = scb.pop_front();
          check("scb_data", O_data, e.data);
          check("scb_illegal", {31'b0, O_illegal}, {31'b0, e.illegal});
        end
      end
    end
  end

  task automatic tick();
    @(posedge I_clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] sel, input logic [31:0] d,
                       input logic [31:0] exp, input logic ill);
    exp_t e;
    I_valid  = v;
    I_immsel = sel;
    I_data   = d;
    if (v) begin
      e.data    = exp;
      e.illegal = ill;
      scb.push_back(e);
    end
  endtask

  vec_t vecs[$];

  initial begin
    logic [31:0] d;
    logic [2:0]  sel;

    vecs.push_back('{"ex_i", 3'd0, 32'h00208463, 32'h00000002, 1'b0});
    vecs.push_back('{"ex_s", 3'd1, 32'h00208463, 32'h00000008, 1'b0});
    vecs.push_back('{"ex_b", 3'd2, 32'h00208463, 32'h00000008, 1'b0});
    vecs.push_back('{"ex_u", 3'd3, 32'h00208463, 32'h00208000, 1'b0});
    vecs.push_back('{"ex_j", 3'd4, 32'h00208463, 32'h00008002, 1'b0});
    vecs.push_back('{"ex_z", 3'd5, 32'h00208463, 32'h00000001, 1'b0});
    vecs.push_back('{"sx_i", 3'd0, 32'hFFF00093, 32'hFFFFFFFF, 1'b0});
    vecs.push_back('{"sx_s", 3'd1, 32'hFE112E23, 32'hFFFFFFFC, 1'b0});
    vecs.push_back('{"rsv6", 3'd6, 32'hFFFFFFFF, 32'h00000000, 1'b1});
    vecs.push_back('{"clr6", 3'd0, 32'h80000000, 32'hFFFFF800, 1'b0});
    vecs.push_back('{"rsv7", 3'd7, 32'h12345678, 32'h00000000, 1'b1});
    vecs.push_back('{"clr7", 3'd3, 32'hFFFFFFFF, 32'hFFFFF000, 1'b0});
    vecs.push_back('{"neg_b", 3'd2, 32'h80000000, 32'hFFFFF000, 1'b0});
    vecs.push_back('{"neg_j", 3'd4, 32'h80000000, 32'hFFF00000, 1'b0});
    vecs.push_back('{"z_nosx", 3'd5, 32'hFFFFFFFF, 32'h0000001F, 1'b0});

    // Reset state
    I_rst = 1'b1;
    drive(1'b0, 3'd0, 32'h0, 32'h0, 1'b0);
    tick();
    tick();
    check("rst_data", O_data, 32'h0);
    check("rst_valid", {31'b0, O_valid}, 32'h0);
    check("rst_illegal", {31'b0, O_illegal}, 32'h0);
    I_rst = 1'b0;
    tick();

    // Table vectors, back to back
    foreach (vecs[i]) begin
      drive(1'b1, vecs[i].sel, vecs[i].d, vecs[i].exp, vecs[i].ill);
      tick();
    end
    drive(1'b0, 3'd0, 32'h0, 32'h0, 1'b0);
    tick();

    // Random vectors against the model, with occasional bubbles
    for (int i = 0; i < 60; i++) begin
      d   = $urandom;
      sel = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) drive(1'b0, sel, d, 32'h0, 1'b0);
      else drive(1'b1, sel, d, model(sel, d), sel > 3'd5);
      tick();
    end
    drive(1'b0, 3'd0, 32'h0, 32'h0, 1'b0);
    tick();
    tick();

    // Single valid pulse, then hold with changing data
    drive(1'b1, 3'd0, 32'h7FF00000, 32'h000007FF, 1'b0);
    tick();
    check("pulse_valid", {31'b0, O_valid}, 32'h1);
    check("pulse_data", O_data, 32'h000007FF);
    drive(1'b0, 3'd3, 32'hDEADBEEF, 32'h0, 1'b0);
    tick();
    check("pulse_drop", {31'b0, O_valid}, 32'h0);
    check("hold_data", O_data, 32'h000007FF);
    I_data   = 32'hA5A5A5A5;
    I_immsel = 3'd6;
    tick();
    check("hold_data2", O_data, 32'h000007FF);
    check("hold_illegal", {31'b0, O_illegal}, 32'h0);

    // Asynchronous reset mid-stream discards the in-flight result
    drive(1'b1, 3'd3, 32'hCAFEB000, 32'hCAFEB000, 1'b0);
    tick();
    check("pre_rst_data", O_data, 32'hCAFEB000);
    drive(1'b1, 3'd7, 32'h11111111, 32'h0, 1'b1);
    #2;
    I_rst = 1'b1;
    #1;
    check("async_rst_data", O_data, 32'h0);
    check("async_rst_valid", {31'b0, O_valid}, 32'h0);
    check("async_rst_illegal", {31'b0, O_illegal}, 32'h0);
    tick();
    I_rst = 1'b0;
    scb.delete();
    drive(1'b1, 3'd4, 32'h00208463, 32'h00008002, 1'b0);
    tick();
    check("post_rst_valid", {31'b0, O_valid}, 32'h1);
    check("post_rst_data", O_data, 32'h00008002);
    drive(1'b0, 3'd0, 32'h0, 32'h0, 1'b0);
    tick();
    tick();

    check("scb_drained", 32'(scb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
